alu_seq: RTL
============

# alu_seq

Sequential, parametrised ALU for the VeriRisc datapath, generalising the combinational accumulator ALU to a configurable width, a wider opcode set, registered results with status flags, and an iterative shift-add multiplier. Operands enter through a valid/ready handshake. Results leave through a second valid/ready handshake, so the controller can stall on multi-cycle operations instead of assuming single-cycle completion.

## Interface
- WIDTH, 8: operand/result width, ≥2
- MUL_EN, 1: 1 enables MUL; 0 makes MUL behave as PASSA
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand/opcode present
- in_ready  out  1  block accepts operands this cycle
- in_a, in_b  in  WIDTH  operands
- opcode  in  4  operation (encodings below)
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer takes result
- alu_out  out  WIDTH  result
- carry  out  1  carry/borrow/shifted-out bit/overflow
- zero  out  1  alu_out == 0
- a_is_zero  out  1  captured in_a == 0 (registered; VeriRisc SKZ support)

## Operation
- Opcodes: 0 PASSA, 1 PASSB, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 SHL1, 8 SHR1, 9 MUL. 10–15 behave as PASSA with carry=0.
- ADD: {carry,alu_out} = a+b, width WIDTH+1.
- SUB: alu_out = a−b mod 2^WIDTH; carry = borrow (a<b unsigned).
- SHL1: carry = a[WIDTH-1], alu_out = a<<1. SHR1: carry = a[0], logical right shift.
- MUL: unsigned shift-add, one multiplier bit per cycle. alu_out = low WIDTH bits of the product. carry = 1 if the high half is nonzero.
- All other ops: carry = 0.
- zero is computed from the final alu_out. a_is_zero is computed from in_a at acceptance.
- FSM states:
  - IDLE: in_ready=1. A handshake with a non-MUL op goes to DONE. A handshake with MUL goes to BUSY and loads the multiplicand, multiplier, 2·WIDTH accumulator and a count of WIDTH.
  - BUSY: in_ready=0. Each cycle adds the multiplicand if the multiplier LSB is set, shifts, and decrements the count. When count reaches 0, go to DONE.
  - DONE: out_valid=1. Outputs hold stable until out_ready. If out_ready is high: with in_valid high, accept the new operation (back-to-back) and go to DONE or BUSY; with in_valid low, go to IDLE.
- in_ready = (state==IDLE) | (state==DONE & out_ready), purely combinational. There is no combinational path from in_* to out_*.
- Inputs are ignored when in_ready=0. Operands are captured at the handshake, so later changes to the inputs have no effect.

## Timing
- Reset (async assert, sync release, any state including mid-MUL): state=IDLE, alu_out=0, carry=0, zero=1, a_is_zero=0, out_valid=0, in_ready=1 once released. A partial product is discarded.
- Non-MUL latency: handshake in cycle N, out_valid in N+1.
- MUL latency: handshake in cycle N, out_valid in N+WIDTH+1.
- Sustained throughput is 1 op/cycle for non-MUL ops when out_ready is held high.
- Result registers update only on an input handshake (captures a_is_zero) or on a transition into DONE.

## Structure
- Package alu_seq_pkg holds:
  - the opcode enum/localparams (OP_PASSA…OP_MUL)
  - the state encoding (ST_IDLE, ST_BUSY, ST_DONE)
  - the flag-bundle typedef
- Sub-module alu_seq_mul: iterative multiplier with a start/done interface, instantiated only when MUL_EN=1 (generate).
- Single-cycle ops stay in one combinational case in the top level.

## Test plan
- Reset: hold rst_n low → alu_out=0, zero=1, out_valid=0, in_ready=1. Release, then ADD 8'hF0+8'h20 → next cycle alu_out=8'h10, carry=1, zero=0.
- SUB 8'h05−8'h07 → alu_out=8'hFE, carry=1. XOR 8'hAA^8'hAA → alu_out=0, zero=1, a_is_zero=0.
- MUL 8'd13×8'd11 → out_valid exactly 9 cycles after the handshake, alu_out=8'h8F, carry=0. MUL 8'hFF×8'h02 → alu_out=8'hFE, carry=1. in_ready=0 throughout BUSY.
- Backpressure: out_ready low for 5 cycles after SHL1 of 8'h81 → alu_out=8'h02 and carry=1 held stable, in_ready=0. Then raise out_ready with a new in_valid → accepted in the same cycle.
- Streaming: 16 random non-MUL ops with out_ready=1 → one result per cycle, all matching the reference model.
- Reset asserted mid-MUL (cycle 4) → immediate IDLE, out_valid=0. After release, the next ADD completes normally.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential VeriRisc ALU: opcodes, FSM states
// and the registered status-flag bundle.
package alu_seq_pkg;

    localparam int OPCODE_W = 4;

    typedef enum logic [OPCODE_W-1:0] {
        OP_PASSA = 4'd0,
        OP_PASSB = 4'd1,
        OP_ADD   = 4'd2,
        OP_SUB   = 4'd3,
        OP_AND   = 4'd4,
        OP_OR    = 4'd5,
        OP_XOR   = 4'd6,
        OP_SHL1  = 4'd7,
        OP_SHR1  = 4'd8,
        OP_MUL   = 4'd9
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic carry;
        logic zero;
        logic aIsZero;
    } flags_t;

    localparam flags_t FLAGS_RESET = '{carry: 1'b0, zero: 1'b1, aIsZero: 1'b0};

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle.
// o_done marks the final step, with o_product already holding the full result.
module alu_seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] w_accNext;
    logic [WIDTH-1:0]   r_mplier;
    logic [CNT_W-1:0]   r_count;

    assign w_accNext = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign o_done    = (r_count == CNT_W'(1));
    assign o_product = w_accNext;

    // A nonzero count means a product is in flight; reset discards it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_count  <= '0;
        end else if (i_start) begin
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_acc    <= '0;
            r_mplier <= i_b;
            r_count  <= CNT_W'(WIDTH);
        end else if (r_count != '0) begin
            r_acc    <= w_accNext;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential VeriRisc ALU with valid/ready operand and result handshakes,
// registered result/flags, and an optional iterative multiplier.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             carry,
    output logic             zero,
    output logic             a_is_zero
);

    state_e               r_state;
    state_e               w_nextState;
    logic [WIDTH-1:0]     r_result;
    flags_t               r_flags;

    logic                 w_accept;
    logic                 w_isMul;
    logic                 w_mulStart;
    logic                 w_mulDone;
    logic [2*WIDTH-1:0]   w_mulProduct;
    logic [WIDTH-1:0]     w_mulLow;
    logic [WIDTH-1:0]     w_mulHigh;

    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_diff;
    logic [WIDTH-1:0]     w_opResult;
    logic                 w_opCarry;

    assign w_isMul    = (MUL_EN != 0) && (opcode == OP_MUL);
    assign w_accept   = in_valid && in_ready;
    assign w_mulStart = w_accept && w_isMul;
    assign w_mulLow   = w_mulProduct[WIDTH-1:0];
    assign w_mulHigh  = w_mulProduct[2*WIDTH-1:WIDTH];

    assign w_sum  = {1'b0, in_a} + {1'b0, in_b};
    assign w_diff = {1'b0, in_a} - {1'b0, in_b};

    generate
        if (MUL_EN != 0) begin : g_mul
            alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
                .clk       (clk),
                .rst_n     (rst_n),
                .i_start   (w_mulStart),
                .i_a       (in_a),
                .i_b       (in_b),
                .o_done    (w_mulDone),
                .o_product (w_mulProduct)
            );
        end else begin : g_noMul
            assign w_mulDone    = 1'b0;
            assign w_mulProduct = '0;
        end
    endgenerate

    // Single-cycle operations; MUL and the unused encodings fall back to PASSA.
    always_comb begin
        w_opResult = in_a;
        w_opCarry  = 1'b0;
        case (opcode)
            OP_PASSB: w_opResult = in_b;
            OP_ADD:   {w_opCarry, w_opResult} = w_sum;
            OP_SUB:   {w_opCarry, w_opResult} = w_diff;
            OP_AND:   w_opResult = in_a & in_b;
            OP_OR:    w_opResult = in_a | in_b;
            OP_XOR:   w_opResult = in_a ^ in_b;
            OP_SHL1: begin
                w_opResult = {in_a[WIDTH-2:0], 1'b0};
                w_opCarry  = in_a[WIDTH-1];
            end
            OP_SHR1: begin
                w_opResult = {1'b0, in_a[WIDTH-1:1]};
                w_opCarry  = in_a[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // in_ready in DONE follows out_ready so a consumed result can be replaced in the same cycle.
    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_nextState = w_isMul ? ST_BUSY : ST_DONE;
                end
            end
            ST_BUSY: begin
                if (w_mulDone) begin
                    w_nextState = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        w_nextState = w_isMul ? ST_BUSY : ST_DONE;
                    end else begin
                        w_nextState = ST_IDLE;
                    end
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_flags  <= FLAGS_RESET;
        end else if (w_accept) begin
            r_flags.aIsZero <= (in_a == '0);
            if (!w_isMul) begin
                r_result      <= w_opResult;
                r_flags.carry <= w_opCarry;
                r_flags.zero  <= (w_opResult == '0);
            end
        end else if ((r_state == ST_BUSY) && w_mulDone) begin
            r_result      <= w_mulLow;
            r_flags.carry <= (w_mulHigh != '0);
            r_flags.zero  <= (w_mulLow == '0);
        end
    end

    assign alu_out   = r_result;
    assign carry     = r_flags.carry;
    assign zero      = r_flags.zero;
    assign a_is_zero = r_flags.aIsZero;

endmodule
